// File: rtl/noise_filter_ma.sv
// noise_filter_ma: multi-channel boxcar moving-average filter
// with noise gate, bypass and flush; valid/ready on both sides.
//
// Ports:
//   clk, reset_n       clock (rising), async active-low reset
//   in_valid/in_ready  input handshake
//   in_ch, in_sample   channel tag and signed sample
//   filter_en          1: averaged output, 0: bypass
//   gate_en            zero outputs with |val| < gate_thresh
//   gate_thresh        gate threshold, unsigned magnitude
//   flush              synchronous clear of all state
//   out_valid/ready    output handshake
//   out_ch, out_sample channel tag and filtered sample
module noise_filter_ma #(
  parameter int BIT_DEPTH = 8,
  parameter int LOG2_WIN  = 2,
  parameter int NUM_CH    = 2,
  parameter int CH_W      = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH_W-1:0]      in_ch,
  input  logic [BIT_DEPTH-1:0] in_sample,
  input  logic                 filter_en,
  input  logic                 gate_en,
  input  logic [BIT_DEPTH-1:0] gate_thresh,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [BIT_DEPTH-1:0] out_sample
);

  localparam int WIN = 1 << LOG2_WIN;
  localparam int SW  = BIT_DEPTH + LOG2_WIN;

  logic [BIT_DEPTH-1:0] hist [NUM_CH][WIN];
  logic [SW-1:0]        sum  [NUM_CH];
  logic [LOG2_WIN-1:0]  ptr  [NUM_CH];

  logic                 accept;
  logic                 ch_ok;
  logic [CH_W-1:0]      ch_idx;
  logic [BIT_DEPTH-1:0] old;
  logic [SW-1:0]        old_x;
  logic [SW-1:0]        in_x;
  logic signed [SW-1:0] new_sum;
  logic signed [SW-1:0] avg_w;
  logic [BIT_DEPTH-1:0] avg;
  logic [BIT_DEPTH-1:0] val;
  logic [BIT_DEPTH-1:0] mag;
  logic [BIT_DEPTH-1:0] res;
  logic                 is_min;
  logic                 gate_hit;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign ch_ok    = int'(in_ch) < NUM_CH;

  // Out-of-range tags read channel 0 harmlessly;
  // the write below is suppressed for them.
  assign ch_idx = ch_ok ? in_ch : '0;
  assign old    = hist[ch_idx][ptr[ch_idx]];

  assign old_x = {{LOG2_WIN{old[BIT_DEPTH-1]}}, old};
  assign in_x  = {{LOG2_WIN{in_sample[BIT_DEPTH-1]}},
                  in_sample};

  assign new_sum = sum[ch_idx] - old_x + in_x;
  assign avg_w   = new_sum >>> LOG2_WIN;
  assign avg     = avg_w[BIT_DEPTH-1:0];
  assign val     = filter_en ? avg : in_sample;

  // Most-negative value has no positive twin;
  // it is exempt from gating.
  assign is_min = val == {1'b1, {(BIT_DEPTH-1){1'b0}}};
  assign mag    = val[BIT_DEPTH-1] ? -val : val;

  assign gate_hit = gate_en && !is_min &&
                    (mag < gate_thresh);
  assign res = gate_hit ? '0 : val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sample <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c] <= '0;
        ptr[c] <= '0;
        for (int i = 0; i < WIN; i++) begin
          hist[c][i] <= '0;
        end
      end
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sample <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c] <= '0;
        ptr[c] <= '0;
        for (int i = 0; i < WIN; i++) begin
          hist[c][i] <= '0;
        end
      end
    end else begin
      if (accept && ch_ok) begin
        hist[ch_idx][ptr[ch_idx]] <= in_sample;
        sum[ch_idx]  <= new_sum;
        ptr[ch_idx]  <= ptr[ch_idx] + 1'b1;
        out_valid    <= 1'b1;
        out_ch       <= in_ch;
        out_sample   <= res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noise_filter_ma.sv
// tb_noise_filter_ma: scoreboard bench for noise_filter_ma
// with a queue-based reference model and random stimulus.
module tb_noise_filter_ma;

  localparam int BD  = 8;
  localparam int LW  = 2;
  localparam int NC  = 3;
  localparam int CW  = 2;
  localparam int WIN = 4;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ch;
  logic [BD-1:0] in_sample;
  logic          filter_en;
  logic          gate_en;
  logic [BD-1:0] gate_thresh;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ch;
  logic [BD-1:0] out_sample;

  noise_filter_ma #(
    .BIT_DEPTH(BD),
    .LOG2_WIN (LW),
    .NUM_CH   (NC),
    .CH_W     (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .in_sample  (in_sample),
    .filter_en  (filter_en),
    .gate_en    (gate_en),
    .gate_thresh(gate_thresh),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_sample (out_sample)
  );

  typedef struct {
    int ch;
    int s;
  } exp_t;

  exp_t exp_q[$];
  int   got_s[$];
  int   got_c[$];
  int   hist_m[NC][$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   rdy_rand = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      hist_m[c].delete();
      repeat (WIN) hist_m[c].push_back(0);
    end
  endfunction

  function automatic int floor_div(input int n);
    int q;
    q = n / WIN;
    if ((n % WIN) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  function automatic void model_apply(
      input int ch, input int s, input bit fen,
      input bit gen, input int thr);
    int total;
    int v;
    int m;
    exp_t e;
    if (ch >= NC) return;
    hist_m[ch].push_back(s);
    void'(hist_m[ch].pop_front());
    total = 0;
    foreach (hist_m[ch][i]) total += hist_m[ch][i];
    v = fen ? floor_div(total) : s;
    m = (v < 0) ? -v : v;
    if (gen && v != -128 && m < thr) v = 0;
    e.ch = ch;
    e.s  = v;
    exp_q.push_back(e);
  endfunction

  task automatic send(input int ch, input int s,
                      input bit fen, input bit gen,
                      input int thr, output int waits);
    logic [7:0] sb;
    logic [7:0] tb8;
    logic [1:0] cb;
    sb  = s[7:0];
    tb8 = thr[7:0];
    cb  = ch[1:0];
    waits = 0;
    @(negedge clk);
    in_valid    = 1'b1;
    in_ch       = cb;
    in_sample   = sb;
    filter_en   = fen;
    gate_en     = gen;
    gate_thresh = tb8;
    #1;
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
      #1;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else model_apply(ch, s, fen, gen, thr);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    in_valid = 1'($urandom_range(0, 1));
    flush = 1'b1;
    #1;
    chk("flush_in_ready", int'(in_ready), 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", int'(out_valid), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_log(input string name, input int idx,
                         input int es, input int ec);
    int as;
    int ac;
    as = (idx < got_s.size()) ? got_s[idx] : 9999;
    ac = (idx < got_c.size()) ? got_c[idx] : 9999;
    chk({name, "_val"}, as, es);
    chk({name, "_ch"}, ac, ec);
  endtask

  initial begin
    int act_s;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && !flush && out_valid) begin
        act_s = int'($signed(out_sample));
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious: got ch %0d val %0d expected none",
                   out_ch, act_s);
        end else begin
          e = exp_q[0];
          chk("sb_val", act_s, e.s);
          chk("sb_ch", int'(out_ch), e.ch);
          if (out_ready) begin
            void'(exp_q.pop_front());
            got_s.push_back(act_s);
            got_c.push_back(int'(out_ch));
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int rs;
    logic [7:0] r8;
    reset_n     = 1'b0;
    in_valid    = 1'b1;
    in_ch       = '0;
    in_sample   = 8'd55;
    filter_en   = 1'b1;
    gate_en     = 1'b0;
    gate_thresh = '0;
    flush       = 1'b0;
    out_ready   = 1'b1;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sample", int'(out_sample), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    #1;
    chk("rst_no_capture", int'(out_valid), 0);

    got_s.delete(); got_c.delete();
    send(0, 40, 1, 0, 0, w); chk("ramp_lat", int'(out_valid), 1);
    send(0, 40, 1, 0, 0, w); chk("ramp_lat", int'(out_valid), 1);
    send(0, 40, 1, 0, 0, w); chk("ramp_lat", int'(out_valid), 1);
    send(0, 40, 1, 0, 0, w); chk("ramp_lat", int'(out_valid), 1);
    send(0, 80, 1, 0, 0, w); chk("ramp_lat", int'(out_valid), 1);
    drain();
    chk_log("ramp0", 0, 10, 0);
    chk_log("ramp1", 1, 20, 0);
    chk_log("ramp2", 2, 30, 0);
    chk_log("ramp3", 3, 40, 0);
    chk_log("ramp4", 4, 50, 0);

    do_flush();
    got_s.delete(); got_c.delete();
    send(0, 100, 1, 0, 0, w);
    send(1, -8, 1, 0, 0, w);
    send(0, 100, 1, 0, 0, w);
    send(1, -8, 1, 0, 0, w);
    drain();
    chk_log("ilv0", 0, 25, 0);
    chk_log("ilv1", 1, -2, 1);
    chk_log("ilv2", 2, 50, 0);
    chk_log("ilv3", 3, -4, 1);

    do_flush();
    got_s.delete(); got_c.delete();
    send(0, 16, 1, 1, 5, w);
    send(0, -20, 1, 1, 5, w);
    send(0, -128, 0, 1, 5, w);
    drain();
    chk_log("gate0", 0, 0, 0);
    chk_log("gate1", 1, 0, 0);
    chk_log("gate_min", 2, -128, 0);

    do_flush();
    got_s.delete(); got_c.delete();
    send(3, 99, 1, 0, 0, w);
    chk("badch_accept_wait", w, 0);
    send(2, 8, 1, 0, 0, w);
    send(0, 40, 1, 0, 0, w);
    drain();
    chk_log("badch0", 0, 2, 2);
    chk_log("badch1", 1, 10, 0);
    chk("badch_count", got_s.size(), 2);

    do_flush();
    got_s.delete(); got_c.delete();
    out_ready = 1'b0;
    send(0, 40, 1, 0, 0, w);
    repeat (3) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 8'd77;
      #1;
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_held_valid", int'(out_valid), 1);
      chk("bp_held_val", int'($signed(out_sample)), 10);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(0, 40, 1, 0, 0, w); chk("bp_wait", w, 0);
    send(0, 40, 1, 0, 0, w); chk("bp_wait", w, 0);
    send(0, 40, 1, 0, 0, w); chk("bp_wait", w, 0);
    drain();
    chk_log("bp0", 0, 10, 0);
    chk_log("bp1", 1, 20, 0);
    chk_log("bp2", 2, 30, 0);
    chk_log("bp3", 3, 40, 0);

    do_flush();
    got_s.delete(); got_c.delete();
    send(0, 40, 1, 0, 0, w);
    send(0, 40, 1, 0, 0, w);
    send(0, 40, 1, 0, 0, w);
    do_flush();
    send(0, 40, 1, 0, 0, w);
    drain();
    chk_log("fl_first", 0, 10, 0);
    chk_log("fl_after", got_s.size() - 1, 10, 0);

    rdy_rand = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_flush();
      end else begin
        r8 = 8'($urandom);
        rs = int'($signed(r8));
        send(int'($urandom_range(0, 3)), rs,
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)),
             int'($urandom_range(0, 40)), w);
      end
    end
    rdy_rand = 1'b0;
    @(negedge clk);
    drain();

    got_s.delete(); got_c.delete();
    out_ready = 1'b0;
    send(1, 100, 1, 0, 0, w);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_sample", int'(out_sample), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(1, 100, 1, 0, 0, w);
    drain();
    chk_log("arst_after", 0, 25, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
